// File: rtl/prog_delay_line_pkg.sv
// Shared types and elaboration-time helpers for the programmable delay line:
// width derivation, delay clamping and the per-channel fill state.
package prog_delay_line_pkg;

  typedef enum logic {
    CH_FILLING = 1'b0,
    CH_VALID   = 1'b1
  } ch_state_e;

  // Index width for n entries, never below one bit.
  function automatic int unsigned pdl_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width able to hold 0..max_delay inclusive.
  function automatic int unsigned pdl_dly_w(input int unsigned max_delay);
    return $clog2(max_delay + 1);
  endfunction

  function automatic int unsigned pdl_clamp(input int unsigned req,
                                            input int unsigned max_delay);
    if (req == 0) return 1;
    if (req > max_delay) return max_delay;
    return req;
  endfunction

  function automatic ch_state_e pdl_state(input int unsigned fill,
                                          input int unsigned dly);
    return (fill >= dly) ? CH_VALID : CH_FILLING;
  endfunction

endpackage

// File: rtl/prog_delay_line_delay_ring_mem.sv
// Ring storage for the delay line: one full-width write port and one
// combinational read port per channel lane.
module delay_ring_mem #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned LANES  = 2,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned AW     = 3
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_waddr,
  input  logic [LANES*LANE_W-1:0]  i_wdata,
  input  logic [LANES*AW-1:0]      i_raddr,
  output logic [LANES*LANE_W-1:0]  o_rdata
);

  logic [LANES*LANE_W-1:0] r_mem [DEPTH];

  // No reset: stale contents are masked by the channel valid logic.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_comb begin
    o_rdata = '0;
    for (int unsigned p = 0; p < LANES; p++) begin
      o_rdata[p*LANE_W +: LANE_W] = r_mem[i_raddr[p*AW +: AW]][p*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/prog_delay_line.sv
// Multi-channel programmable cycle-delay line: each channel delays its input
// lane by a run-time programmable number of enabled clock cycles.
module prog_delay_line
  import prog_delay_line_pkg::*;
#(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned MAX_DELAY     = 8,
  parameter int unsigned DEFAULT_DELAY = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic                               flush,
  input  logic [CHANNELS*WIDTH-1:0]          in_data,
  input  logic                               cfg_we,
  input  logic [pdl_idx_w(CHANNELS)-1:0]     cfg_ch,
  input  logic [pdl_dly_w(MAX_DELAY)-1:0]    cfg_delay,
  output logic [CHANNELS*WIDTH-1:0]          out_data,
  output logic [CHANNELS-1:0]                out_valid
);

  localparam int unsigned DLY_W = pdl_dly_w(MAX_DELAY);
  localparam int unsigned PTR_W = pdl_idx_w(MAX_DELAY);
  localparam int unsigned DW    = CHANNELS * WIDTH;

  logic [PTR_W-1:0]      r_wp;
  logic [DLY_W-1:0]      r_fill     [CHANNELS];
  logic [DLY_W-1:0]      r_dly      [CHANNELS];
  logic [DW-1:0]         r_out_data;
  logic [CHANNELS-1:0]   r_out_valid;

  logic                  w_adv;
  logic                  w_cfg_hit;
  logic [DLY_W-1:0]      w_cfg_dly;
  logic [CHANNELS-1:0]   w_sel;
  logic [DLY_W-1:0]      w_fill_nxt [CHANNELS];
  logic [CHANNELS-1:0]   w_val_nxt;
  logic [DW-1:0]         w_dat_nxt;
  logic [CHANNELS*PTR_W-1:0] w_rd_addr;
  logic [DW-1:0]         w_rd_data;

  assign w_adv     = en & ~flush;
  assign w_cfg_hit = cfg_we & (32'(cfg_ch) < CHANNELS);
  assign w_cfg_dly = DLY_W'(pdl_clamp(32'(cfg_delay), MAX_DELAY));

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

  delay_ring_mem #(
    .DEPTH  (MAX_DELAY),
    .LANES  (CHANNELS),
    .LANE_W (WIDTH),
    .AW     (PTR_W)
  ) u_ring (
    .clk     (clk),
    .i_we    (w_adv),
    .i_waddr (r_wp),
    .i_wdata (in_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // Read address is taken before this edge's write: sample d-1 back sits at
  // wp-(d-1); d=1 bypasses the ring and registers in_data directly.
  always_comb begin
    w_sel     = '0;
    w_val_nxt = '0;
    w_dat_nxt = '0;
    w_rd_addr = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_sel[c] = w_cfg_hit && (32'(cfg_ch) == c);
      w_rd_addr[c*PTR_W +: PTR_W] =
        PTR_W'((32'(r_wp) + MAX_DELAY + 1 - 32'(r_dly[c])) % MAX_DELAY);
      w_fill_nxt[c] = (32'(r_fill[c]) < MAX_DELAY) ? r_fill[c] + DLY_W'(1)
                                                   : r_fill[c];
      w_val_nxt[c] = (pdl_state(32'(w_fill_nxt[c]), 32'(r_dly[c])) == CH_VALID);
      if (w_val_nxt[c]) begin
        w_dat_nxt[c*WIDTH +: WIDTH] = (r_dly[c] == DLY_W'(1))
                                      ? in_data[c*WIDTH +: WIDTH]
                                      : w_rd_data[c*WIDTH +: WIDTH];
      end
    end
  end

  // A config write to a channel overrides its advance/flush results for that
  // edge (later non-blocking assignments win), leaving other channels alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp        <= '0;
      r_out_data  <= '0;
      r_out_valid <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_fill[c] <= '0;
        r_dly[c]  <= DLY_W'(DEFAULT_DELAY);
      end
    end else begin
      if (flush) begin
        r_wp        <= '0;
        r_out_data  <= '0;
        r_out_valid <= '0;
        for (int unsigned c = 0; c < CHANNELS; c++) r_fill[c] <= '0;
      end else if (en) begin
        r_wp        <= (32'(r_wp) == MAX_DELAY - 1) ? '0 : r_wp + PTR_W'(1);
        r_out_data  <= w_dat_nxt;
        r_out_valid <= w_val_nxt;
        for (int unsigned c = 0; c < CHANNELS; c++) r_fill[c] <= w_fill_nxt[c];
      end
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (w_sel[c]) begin
          r_dly[c]                     <= w_cfg_dly;
          r_fill[c]                    <= '0;
          r_out_valid[c]               <= 1'b0;
          r_out_data[c*WIDTH +: WIDTH] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench for prog_delay_line: a history-shift model feeds a scoreboard
// queue at drive time; entries are popped and compared after each edge.
module tb_prog_delay_line;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, flush;
  logic [15:0] in_data;
  logic        cfg_we;
  logic [0:0]  cfg_ch;
  logic [3:0]  cfg_delay;
  logic [15:0] out_data;
  logic [1:0]  out_valid;

  logic [23:0] in_data3;
  logic        cfg_we3;
  logic [1:0]  cfg_ch3;
  logic [3:0]  cfg_delay3;
  logic [23:0] out_data3;
  logic [2:0]  out_valid3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prog_delay_line #(
    .CHANNELS(2), .WIDTH(8), .MAX_DELAY(8), .DEFAULT_DELAY(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
    .out_data(out_data), .out_valid(out_valid)
  );

  // Three-channel instance so an out-of-range channel index is representable.
  prog_delay_line #(
    .CHANNELS(3), .WIDTH(8), .MAX_DELAY(8), .DEFAULT_DELAY(4)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_data(in_data3),
    .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_delay(cfg_delay3),
    .out_data(out_data3), .out_valid(out_valid3)
  );

  typedef struct packed {
    logic [1:0]  v;
    logic [15:0] d;
    logic [2:0]  v3;
    logic [23:0] d3;
  } exp_t;

  exp_t sb_q[$];

  // Lanes 0,1 model u_dut channels; lanes 2..4 model u_dut3 channels.
  logic [7:0] m_hist [5][16];
  int         m_cnt  [5];
  int         m_dly  [5];
  logic [7:0] m_out  [5];
  logic       m_val  [5];
  logic [7:0] seq = 8'd1;
  int         step_no = 0;

  function automatic int clampd(input int req);
    if (req == 0) return 1;
    if (req > 8) return 8;
    return req;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 5; l++) begin
      m_cnt[l] = 0; m_dly[l] = 4; m_out[l] = 8'h00; m_val[l] = 1'b0;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.v  = {m_val[1], m_val[0]};
    e.d  = {m_out[1], m_out[0]};
    e.v3 = {m_val[4], m_val[3], m_val[2]};
    e.d3 = {m_out[4], m_out[3], m_out[2]};
    sb_q.push_back(e);
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    assert ({out_valid, out_data} === {e.v, e.d}) else begin
      failures++;
      $error("FAIL %s#%0d main observed=%h expected=%h", tag, step_no,
             {out_valid, out_data}, {e.v, e.d});
    end
    checks++;
    assert ({out_valid3, out_data3} === {e.v3, e.d3}) else begin
      failures++;
      $error("FAIL %s#%0d ch3dut observed=%h expected=%h", tag, step_no,
             {out_valid3, out_data3}, {e.v3, e.d3});
    end
  endtask

  task automatic step(input logic s_en, input logic s_flush, input logic s_we,
                      input logic s_ch, input logic [3:0] s_dly,
                      input logic [7:0] s_d0, input logic [7:0] s_d1,
                      input logic s_we3, input logic [1:0] s_ch3,
                      input logic [3:0] s_dly3, input string tag);
    logic [7:0] lin [5];
    logic       hit;
    @(negedge clk);
    en = s_en; flush = s_flush;
    cfg_we = s_we; cfg_ch = s_ch; cfg_delay = s_dly;
    cfg_we3 = s_we3; cfg_ch3 = s_ch3; cfg_delay3 = s_dly3;
    lin[0] = s_d0; lin[1] = s_d1;
    lin[2] = s_d0 ^ 8'h5A; lin[3] = s_d1 + 8'h11; lin[4] = s_d0 + s_d1;
    in_data  = {lin[1], lin[0]};
    in_data3 = {lin[4], lin[3], lin[2]};
    for (int l = 0; l < 5; l++) begin
      hit = (l < 2) ? (s_we && (int'(s_ch) == l))
                    : (s_we3 && (int'(s_ch3) == l - 2));
      if (s_flush || hit) begin
        m_cnt[l] = 0; m_val[l] = 1'b0; m_out[l] = 8'h00;
      end else if (s_en) begin
        for (int j = 15; j > 0; j--) m_hist[l][j] = m_hist[l][j-1];
        m_hist[l][0] = lin[l];
        if (m_cnt[l] < 16) m_cnt[l]++;
        m_val[l] = (m_cnt[l] >= m_dly[l]);
        m_out[l] = m_val[l] ? m_hist[l][m_dly[l]-1] : 8'h00;
      end
      if (hit) m_dly[l] = clampd(int'(l < 2 ? s_dly : s_dly3));
    end
    push_expect();
    @(posedge clk);
    #1;
    step_no++;
    check_now(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, seq, seq ^ 8'hC3,
           1'b0, 2'd0, 4'd0, tag);
      seq++;
    end
  endtask

  task automatic cfg(input logic ch, input logic [3:0] dly, input logic s_en,
                     input string tag);
    step(s_en, 1'b0, 1'b1, ch, dly, seq, seq ^ 8'hC3, 1'b0, 2'd0, 4'd0, tag);
    seq++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat_en;
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; in_data = '0; in_data3 = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_delay = '0;
    cfg_we3 = 1'b0; cfg_ch3 = '0; cfg_delay3 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    push_expect();
    check_now("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run(7, "fill_d4");

    cfg(1'b1, 4'd1, 1'b1, "cfg_d1");
    run(4, "track_d1");
    cfg(1'b1, 4'd0, 1'b0, "cfg_d0_en0");
    run(3, "track_d0");
    cfg(1'b1, 4'd12, 1'b1, "cfg_d12");
    run(10, "fill_d8");

    cfg(1'b0, 4'd2, 1'b1, "cfg_ch0_d2");
    run(3, "d2_fill");
    pat_en = 8'b1011_0011;
    for (int i = 0; i < 7; i++) begin
      step(pat_en[6-i], 1'b0, 1'b0, 1'b0, 4'd0, seq, seq ^ 8'hC3,
           1'b0, 2'd0, 4'd0, "en_pat");
      seq++;
    end

    cfg(1'b0, 4'd4, 1'b1, "cfg_ch0_d4");
    run(6, "d4_run");
    cfg(1'b0, 4'd2, 1'b1, "cfg_ch0_4to2");
    run(4, "d2_refill");

    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, seq, seq, 1'b0, 2'd0, 4'd0, "flush");
    seq++;
    run(9, "post_flush");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, seq, seq, 1'b0, 2'd0, 4'd0, "flush_cfg");
    seq++;
    run(5, "post_flush_cfg");

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    push_expect();
    check_now("async_rst");
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    run(6, "after_rst_d4");

    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, seq, seq, 1'b1, 2'd3, 4'd1, "cfg_ch3");
    seq++;
    run(5, "ignored_cfg");
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, seq, seq, 1'b1, 2'd2, 4'd2, "cfg3_ch2");
    seq++;
    for (int i = 0; i < 24; i++) begin
      step(($urandom_range(0, 3) != 0), 1'b0, 1'b0, 1'b0, 4'd0,
           8'($urandom), 8'($urandom), 1'b0, 2'd0, 4'd0, "wrap");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
